// File: rtl/imem_fetch_seq.sv
// Fetch sequencer: owns the PC, reads the combinational instruction memory and
// registers each fetched word into the IF/ID slot. Handles halt words, redirects and faults.
module imem_fetch_seq #(
    parameter int                 WIDTH     = 32,
    parameter int                 DEPTH     = 5,
    parameter logic [31:0]        RESET_PC  = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   HALT_WORD = '1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             imem_rd_en_o,
    output logic [DEPTH-1:0] imem_addr_o,
    input  logic [WIDTH-1:0] imem_data_i,
    output logic [WIDTH-1:0] instr_o,
    output logic [31:0]      pc_o,
    output logic             valid_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [15:0]      fetch_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    localparam logic [31:0] PC_LIMIT = 32'd4 << DEPTH;
    localparam logic [31:0] LAST_PC  = PC_LIMIT - 32'd4;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [31:0]      r_pc_out;
    logic             r_valid;
    logic             r_fault;
    logic [15:0]      r_cnt;
    logic             w_is_halt;
    logic             w_at_last;

    function automatic logic pc_ok(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc < PC_LIMIT);
    endfunction

    function automatic logic [15:0] cnt_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    assign w_is_halt = (imem_data_i == HALT_WORD);
    assign w_at_last = (r_pc == LAST_PC);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_RUN;
                        r_pc    <= RESET_PC;
                    end
                end
                S_RUN: begin
                    if (redirect_i) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                        if (pc_ok(redirect_pc_i)) begin
                            r_pc <= redirect_pc_i;
                        end else begin
                            r_state <= S_HALT;
                            r_fault <= 1'b1;
                        end
                    end else if (!stall_i) begin
                        r_instr  <= imem_data_i;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_cnt    <= cnt_inc(r_cnt);
                        // A halt word wins over running off the end: no fault then.
                        if (w_is_halt) begin
                            r_state <= S_HALT;
                        end else if (w_at_last) begin
                            r_state <= S_HALT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end
                end
                S_HALT: begin
                    // Last delivered word stays valid for exactly one HALT cycle.
                    r_valid <= 1'b0;
                    if (start_i) begin
                        r_state <= S_RUN;
                        r_pc    <= RESET_PC;
                        r_fault <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_rd_en_o = (r_state == S_RUN);
    assign halted_o     = (r_state == S_HALT);
    assign imem_addr_o  = r_pc[DEPTH+1:2];
    assign instr_o      = r_instr;
    assign pc_o         = r_pc_out;
    assign valid_o      = r_valid;
    assign fault_o      = r_fault;
    assign fetch_cnt_o  = r_cnt;

endmodule
